sn74xx93_seq: RTL and testbench



---
 rtl/sn74_pkg.sv | 27 ++
 rtl/sn74_seq_timer.sv | 36 +++
 rtl/sn74xx93_seq.sv | 139 +++++++++++++
 tb/tb_sn74xx93_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn74_pkg.sv
// Shared state encoding and constants for the SN74XX93 sequencer.
package sn74_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StClr    = 4'd0;
    localparam state_t StIdle   = 4'd1;
    localparam state_t StStep   = 4'd2;
    localparam state_t StLo     = 4'd3;
    localparam state_t StHi     = 4'd4;
    localparam state_t StWrap   = 4'd5;
    localparam state_t StSettle = 4'd6;
    localparam state_t StCheck  = 4'd7;
    localparam state_t StFin    = 4'd8;

    localparam logic [3:0] MOD16_CODE = 4'd0;
    localparam int unsigned TimerW = 4;

    // Shadow value at which the next step clears instead of counting (N-1).
    function automatic logic [3:0] wrap_value(input logic [3:0] mod_val);
        if (mod_val == MOD16_CODE) begin
            return 4'd15;
        end
        return mod_val - 4'd1;
    endfunction

endpackage

// File: rtl/sn74_seq_timer.sv
// Settle down-counter: load starts a CYC-cycle wait, expire_o marks its last cycle.
module sn74_seq_timer
    import sn74_pkg::*;
#(
    parameter int unsigned CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expire_o
);

    localparam logic [TimerW-1:0] LoadVal = TimerW'(CYC - 1);

    logic [TimerW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/sn74xx93_seq.sv
// Sequencer driving one SN74XX93 ripple counter as a modulo-N event counter,
// with a shadow count checked against the counter readback after every step.
module sn74xx93_seq
    import sn74_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned RUN_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       mod_val_i,
    input  logic [RUN_W-1:0] run_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             tc_o,
    output logic [3:0]       shadow_o,
    output logic             cnt_clka_o,
    output logic             cnt_clkb_o,
    output logic             cnt_r0_o,
    output logic             cnt_r1_o,
    input  logic [3:0]       cnt_q_i
);

    state_t           state_q, state_d;
    logic [3:0]       mod_q, mod_d;
    logic [RUN_W-1:0] steps_q, steps_d;
    logic [3:0]       shadow_q, shadow_d;
    logic             err_q, err_d;
    logic             clka_q, clkb_q, clr_q, tc_q, done_q, busy_q;
    logic             wrap_hit;
    logic             timer_load, timer_expire;

    assign wrap_hit   = (shadow_q == wrap_value(mod_q));
    assign timer_load = (state_q == StHi) || (state_q == StWrap);

    sn74_seq_timer #(
        .CYC(SETTLE_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (timer_load),
        .expire_o(timer_expire)
    );

    always_comb begin
        state_d  = state_q;
        mod_d    = mod_q;
        steps_d  = steps_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        case (state_q)
            StClr: state_d = StIdle;
            StIdle: begin
                if (start_i) begin
                    mod_d   = mod_val_i;
                    steps_d = run_len_i;
                    err_d   = 1'b0;
                    if (mod_val_i == 4'd1) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else if (run_len_i == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StStep;
                    end
                end
            end
            StStep: state_d = wrap_hit ? StWrap : StLo;
            StLo: begin
                shadow_d = shadow_q + 4'd1;
                state_d  = StHi;
            end
            StHi: state_d = StSettle;
            StWrap: begin
                shadow_d = 4'd0;
                state_d  = StSettle;
            end
            StSettle: if (timer_expire) state_d = StCheck;
            StCheck: begin
                if (cnt_q_i != shadow_q) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    steps_d = steps_q - 1'b1;
                    // Next step is decided here directly so a count step costs 3+SETTLE_CYC.
                    if (steps_d == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = wrap_hit ? StWrap : StLo;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StClr;
        endcase
    end

    // Counter controls are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StClr;
            mod_q    <= MOD16_CODE;
            steps_q  <= '0;
            shadow_q <= 4'd0;
            err_q    <= 1'b0;
            clka_q   <= 1'b1;
            clkb_q   <= 1'b1;
            clr_q    <= 1'b1;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mod_q    <= mod_d;
            steps_q  <= steps_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            clka_q   <= (state_d != StLo);
            clkb_q   <= !((state_d == StLo) && shadow_q[0]);
            clr_q    <= (state_d == StClr) || (state_d == StWrap);
            tc_q     <= (state_d == StWrap);
            done_q   <= (state_d == StFin);
            busy_q   <= !(state_d inside {StClr, StIdle, StFin});
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign tc_o       = tc_q;
    assign shadow_o   = shadow_q;
    assign cnt_clka_o = clka_q;
    assign cnt_clkb_o = clkb_q;
    assign cnt_r0_o   = clr_q;
    assign cnt_r1_o   = clr_q;

endmodule

// File: tb/tb_sn74xx93_seq.sv
// Bench for sn74xx93_seq: behavioural SN74XX93 plus a scoreboard of predicted steps and run results.
module tb_sn74xx93_seq;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] mod_val_i = 4'd0;
    logic [7:0] run_len_i = 8'd0;
    logic       busy_o, done_o, err_o, tc_o;
    logic [3:0] shadow_o;
    logic       cnt_clka_o, cnt_clkb_o, cnt_r0_o, cnt_r1_o;
    logic [3:0] cnt_q_i;

    logic       qa = 1'b0;
    logic [2:0] qb = 3'd0;
    logic [3:0] stuck = 4'd0;
    logic       clr;

    int n_cmp = 0;
    int n_fail = 0;
    int tc_seen = 0;
    int cyc_cnt = 0;
    int start_edge = 0;
    int clka_falls = 0;
    logic [3:0] model_sh = 4'd0;

    typedef struct {
        int         lat;
        logic       err;
        logic [3:0] sh;
        logic [3:0] cnt;
        int         tcs;
    } res_t;

    res_t       res_q[$];
    logic [3:0] exp_q[$];

    sn74xx93_seq #(
        .SETTLE_CYC(S),
        .RUN_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .mod_val_i (mod_val_i),
        .run_len_i (run_len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .tc_o      (tc_o),
        .shadow_o  (shadow_o),
        .cnt_clka_o(cnt_clka_o),
        .cnt_clkb_o(cnt_clkb_o),
        .cnt_r0_o  (cnt_r0_o),
        .cnt_r1_o  (cnt_r1_o),
        .cnt_q_i   (cnt_q_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SN74XX93: divide-by-2 A stage and divide-by-8 B stage, both falling-edge, cleared by r0&r1.
    assign clr     = cnt_r0_o & cnt_r1_o;
    assign cnt_q_i = {qb, qa} & ~stuck;
    always @(negedge cnt_clka_o or posedge clr) if (clr) qa <= 1'b0; else qa <= ~qa;
    always @(negedge cnt_clkb_o or posedge clr) if (clr) qb <= 3'd0; else qb <= qb + 3'd1;
    always @(negedge cnt_clka_o) clka_falls <= clka_falls + 1;

    task automatic predict(input logic [3:0] m, input logic [7:0] len);
        res_t r;
        logic [3:0] last;
        r.lat = 0;
        r.err = 1'b0;
        r.tcs = 0;
        last = (m == 4'd0) ? 4'd15 : m - 4'd1;
        if (m == 4'd1) begin
            r.err = 1'b1;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                if (model_sh == last) begin
                    model_sh = 4'd0;
                    r.tcs++;
                    r.lat += 2 + int'(S);
                end else begin
                    model_sh = model_sh + 4'd1;
                    r.lat += 3 + int'(S);
                end
                exp_q.push_back(model_sh);
                if ((model_sh & ~stuck) != model_sh) begin
                    r.err = 1'b1;
                    break;
                end
            end
        end
        // One STEP decision cycle precedes the first step.
        if (r.lat != 0) r.lat += 1;
        r.sh  = model_sh;
        r.cnt = model_sh & ~stuck;
        res_q.push_back(r);
    endtask

    task automatic run(input logic [3:0] m, input logic [7:0] len, input bit poke);
        predict(m, len);
        tc_seen = 0;
        @(negedge clk);
        start_i   = 1'b1;
        mod_val_i = m;
        run_len_i = len;
        @(posedge clk);
        #1;
        start_edge = cyc_cnt;
        start_i = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            start_i   = 1'b1;
            mod_val_i = 4'd2;
            run_len_i = 8'd1;
            @(negedge clk);
            start_i = 1'b0;
        end
        for (int i = 0; i < 2000 && res_q.size() != 0; i++) @(posedge clk);
        if (res_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: mod=%0d len=%0d, done not seen within 2000 cycles", m, len);
            res_q.delete();
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        res_q.delete();
        model_sh = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard: steps are checked as the shadow moves, run results when done pulses.
    initial begin : monitor
        logic [3:0] prev_sh;
        logic       prev_done;
        logic [3:0] e;
        res_t       r;
        prev_sh = 4'd0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_sh = 4'd0;
                prev_done = 1'b0;
            end else begin
                if (shadow_o !== prev_sh) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL step_unexpected: shadow moved to %0d, no step expected", shadow_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (shadow_o !== e) begin
                            n_fail++;
                            $display("FAIL step_shadow: got %0d, want %0d", shadow_o, e);
                        end
                    end
                    prev_sh = shadow_o;
                end
                if (tc_o === 1'b1) tc_seen++;
                if (done_o === 1'b1) begin
                    n_cmp++;
                    if (prev_done) begin
                        n_fail++;
                        $display("FAIL done_width: done high two cycles in a row");
                    end
                    n_cmp++;
                    if (res_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL done_unexpected: done with no run pending");
                    end else begin
                        r = res_q.pop_front();
                        n_cmp += 6;
                        if (err_o !== r.err) begin
                            n_fail++;
                            $display("FAIL run_err: got %b, want %b", err_o, r.err);
                        end
                        if (shadow_o !== r.sh) begin
                            n_fail++;
                            $display("FAIL run_shadow: got %0d, want %0d", shadow_o, r.sh);
                        end
                        if (cnt_q_i !== r.cnt) begin
                            n_fail++;
                            $display("FAIL run_cnt_q: got %0d, want %0d", cnt_q_i, r.cnt);
                        end
                        if (tc_seen != r.tcs) begin
                            n_fail++;
                            $display("FAIL run_tc_count: got %0d, want %0d", tc_seen, r.tcs);
                        end
                        if (cyc_cnt - start_edge != r.lat) begin
                            n_fail++;
                            $display("FAIL run_latency: got %0d, want %0d", cyc_cnt - start_edge, r.lat);
                        end
                        if (busy_o !== 1'b0 || exp_q.size() != 0) begin
                            n_fail++;
                            $display("FAIL run_end: busy=%b pending_steps=%0d, want 0/0", busy_o, exp_q.size());
                        end
                    end
                end
                prev_done = done_o;
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 4;
        if ({cnt_r0_o, cnt_r1_o, cnt_clka_o, cnt_clkb_o} !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_cnt_ctl: got %b, want 1111",
                     {cnt_r0_o, cnt_r1_o, cnt_clka_o, cnt_clkb_o});
        end
        if ({busy_o, done_o, err_o, tc_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 0000", {busy_o, done_o, err_o, tc_o});
        end
        if (shadow_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_shadow: got %0d, want 0", shadow_o);
        end
        if (cnt_q_i !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt_q: got %0d, want 0", cnt_q_i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({cnt_r0_o, cnt_r1_o, busy_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL release_clear: r0/r1/busy got %b, want 000", {cnt_r0_o, cnt_r1_o, busy_o});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mod16();
        int f0;
        f0 = clka_falls;
        run(4'd0, 8'd16, 1'b0);
        n_cmp++;
        if (clka_falls - f0 != 15) begin
            n_fail++;
            $display("FAIL mod16_clka_edges: got %0d, want 15", clka_falls - f0);
        end
    endtask

    task automatic test_mod10();
        int f0;
        f0 = clka_falls;
        run(4'd10, 8'd25, 1'b0);
        n_cmp++;
        if (clka_falls - f0 != 23) begin
            n_fail++;
            $display("FAIL mod10_clka_edges: got %0d, want 23", clka_falls - f0);
        end
    endtask

    task automatic test_illegal();
        int f0;
        do_reset();
        f0 = clka_falls;
        run(4'd1, 8'd5, 1'b0);
        n_cmp++;
        if (clka_falls != f0 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_mod: edges=%0d err=%b, want 0 edges err=1", clka_falls - f0, err_o);
        end
        run(4'd4, 8'd2, 1'b0);
        n_cmp++;
        if (err_o !== 1'b0 || cnt_q_i !== 4'd2) begin
            n_fail++;
            $display("FAIL illegal_recover: err=%b cnt_q=%0d, want 0/2", err_o, cnt_q_i);
        end
    endtask

    task automatic test_stuck();
        do_reset();
        stuck = 4'b0100;
        run(4'd0, 8'd8, 1'b0);
        n_cmp++;
        if (err_o !== 1'b1 || shadow_o !== 4'd4) begin
            n_fail++;
            $display("FAIL stuck_sticky: err=%b shadow=%0d, want 1/4", err_o, shadow_o);
        end
        stuck = 4'd0;
    endtask

    task automatic test_reset_mid_run();
        bit found;
        predict(4'd0, 8'd5);
        @(negedge clk);
        start_i   = 1'b1;
        mod_val_i = 4'd0;
        run_len_i = 8'd5;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (cnt_clka_o === 1'b0) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrun_lo: cnt_clka never went low, want low within 40 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        res_q.delete();
        model_sh = 4'd0;
        n_cmp += 2;
        if ({cnt_clka_o, cnt_clkb_o, cnt_r0_o, cnt_r1_o} !== 4'b1111) begin
            n_fail++;
            $display("FAIL midrun_async: clka/clkb/r0/r1 got %b, want 1111",
                     {cnt_clka_o, cnt_clkb_o, cnt_r0_o, cnt_r1_o});
        end
        if (busy_o !== 1'b0 || shadow_o !== 4'd0) begin
            n_fail++;
            $display("FAIL midrun_state: busy=%b shadow=%0d, want 0/0", busy_o, shadow_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (cnt_q_i !== 4'd0 || cnt_r0_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_release: cnt_q=%0d r0=%b busy=%b, want 0/0/0",
                     cnt_q_i, cnt_r0_o, busy_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run(4'd4, 8'd3, 1'b1);
        run(4'd4, 8'd2, 1'b0);
        n_cmp++;
        if (err_o !== 1'b0 || cnt_q_i !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_final: err=%b cnt_q=%0d, want 0/1", err_o, cnt_q_i);
        end
    endtask

    initial begin
        test_reset();
        test_mod16();
        test_mod10();
        test_illegal();
        test_stuck();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
